// File: rtl/decode_hazard_scheduler.sv
// Decode-stage issue scheduler: per-register pending-write scoreboard
// plus sequencing of the single shared multiply/divide unit.
module decode_hazard_scheduler #(
    parameter int CNT_W = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       dec_valid,
    input  logic [4:0] reg_S1,
    input  logic [4:0] reg_S2,
    input  logic [4:0] reg_D,
    input  logic       uses_s1,
    input  logic       uses_s2,
    input  logic       writes_d,
    input  logic       is_md,
    input  logic       wb_valid,
    input  logic [4:0] wb_reg,
    input  logic       md_done,
    input  logic       flush,
    output logic       issue,
    output logic       stall,
    output logic       md_start,
    output logic       md_busy
);

    typedef enum logic {IDLE, MD_BUSY} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [32];
    state_t           state_q, state_d;

    logic haz_s1, haz_s2, haz_d, haz_md;

    // A count of exactly one retiring this cycle is forwarded by the regfile
    always_comb begin
        haz_s1 = uses_s1 && (reg_S1 != 5'd0) && (cnt[reg_S1] != '0) &&
                 !((cnt[reg_S1] == CNT_ONE) && wb_valid && (wb_reg == reg_S1));
        haz_s2 = uses_s2 && (reg_S2 != 5'd0) && (cnt[reg_S2] != '0) &&
                 !((cnt[reg_S2] == CNT_ONE) && wb_valid && (wb_reg == reg_S2));
        haz_d  = writes_d && (reg_D != 5'd0) && (cnt[reg_D] == CNT_MAX) &&
                 !(wb_valid && (wb_reg == reg_D));
        haz_md = is_md && (state_q == MD_BUSY) && !md_done;
    end

    assign issue    = dec_valid && !flush && !(haz_s1 || haz_s2 || haz_d || haz_md);
    assign stall    = dec_valid && !issue && !flush;
    assign md_start = issue && is_md;
    assign md_busy  = (state_q == MD_BUSY);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                logic inc, dec;
                inc = issue && writes_d && (reg_D == 5'(r));
                dec = wb_valid && (wb_reg == 5'(r)) && (cnt[r] != '0);
                if (inc && !dec)
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (dec && !inc)
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (md_start) state_d = MD_BUSY;
                MD_BUSY: if (md_done && !md_start) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_hazard_scheduler.sv
// Directed bench for decode_hazard_scheduler: RAW stalls, r0, saturation,
// multdiv sequencing, flush and reset.
module tb_decode_hazard_scheduler;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       dec_valid;
    logic [4:0] reg_S1, reg_S2, reg_D, wb_reg;
    logic       uses_s1, uses_s2, writes_d, is_md;
    logic       wb_valid, md_done, flush;
    logic       issue, stall, md_start, md_busy;

    int n_vec = 0;
    int n_err = 0;

    decode_hazard_scheduler #(.CNT_W(2)) dut (
        .clock(clock), .reset_n(reset_n), .dec_valid(dec_valid),
        .reg_S1(reg_S1), .reg_S2(reg_S2), .reg_D(reg_D),
        .uses_s1(uses_s1), .uses_s2(uses_s2), .writes_d(writes_d),
        .is_md(is_md), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .md_done(md_done), .flush(flush), .issue(issue), .stall(stall),
        .md_start(md_start), .md_busy(md_busy)
    );

    always #5 clock = ~clock;

    // advance one clock; inputs change 1ns after the edge, checks at +3ns
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid = 0; reg_S1 = 0; reg_S2 = 0; reg_D = 0;
        uses_s1 = 0; uses_s2 = 0; writes_d = 0; is_md = 0;
        wb_valid = 0; wb_reg = 0; md_done = 0; flush = 0;
    endtask

    task automatic test_reset();
        logic bad;
        idle_inputs();
        reset_n = 0;
        dec_valid = 1; uses_s1 = 1; reg_S1 = 5; uses_s2 = 1; reg_S2 = 6;
        #2;
        n_vec++;
        if (issue !== 1'b1) begin
            n_err++; $display("FAIL reset_issue_in_reset got=%b exp=1", issue);
        end
        step(); step();
        reset_n = 1;
        #2;
        bad = 0;
        for (int r = 0; r < 32; r++) if (dut.cnt[r] !== 2'd0) bad = 1;
        n_vec++;
        if (bad) begin
            n_err++; $display("FAIL reset_cnt_all_zero got=nonzero exp=0");
        end
        n_vec++;
        if ({issue, stall, md_busy} !== 3'b100) begin
            n_err++; $display("FAIL reset_idle_outputs got=%b exp=100", {issue, stall, md_busy});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_raw();
        dec_valid = 1; writes_d = 1; reg_D = 3;
        #2;
        n_vec++;
        if (issue !== 1'b1) begin
            n_err++; $display("FAIL raw_writer_issue got=%b exp=1", issue);
        end
        step();
        writes_d = 0; uses_s2 = 1; reg_S2 = 3;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_vec++;
            if ({issue, stall} !== 2'b01) begin
                n_err++; $display("FAIL raw_reader_stall cyc=%0d got=%b exp=01", i, {issue, stall});
            end
            step();
        end
        wb_valid = 1; wb_reg = 3;
        #2;
        n_vec++;
        if ({issue, stall} !== 2'b10) begin
            n_err++; $display("FAIL raw_wb_release got=%b exp=10", {issue, stall});
        end
        step();
        idle_inputs();
        #2;
        n_vec++;
        if (dut.cnt[3] !== 2'd0) begin
            n_err++; $display("FAIL raw_cnt3_after_wb got=%0d exp=0", dut.cnt[3]);
        end
        step();
    endtask

    task automatic test_r0_saturation();
        dec_valid = 1; writes_d = 1; reg_D = 0;
        step();
        writes_d = 0; uses_s1 = 1; reg_S1 = 0;
        #2;
        n_vec++;
        if ({issue, stall} !== 2'b10 || dut.cnt[0] !== 2'd0) begin
            n_err++; $display("FAIL r0_reader got=%b cnt0=%0d exp=10 cnt0=0", {issue, stall}, dut.cnt[0]);
        end
        step();
        uses_s1 = 0; writes_d = 1; reg_D = 7;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_vec++;
            if (issue !== 1'b1) begin
                n_err++; $display("FAIL sat_writer_issue n=%0d got=%b exp=1", i, issue);
            end
            step();
        end
        #2;
        n_vec++;
        if (dut.cnt[7] !== 2'd3) begin
            n_err++; $display("FAIL sat_cnt7_full got=%0d exp=3", dut.cnt[7]);
        end
        n_vec++;
        if ({issue, stall} !== 2'b01) begin
            n_err++; $display("FAIL sat_fourth_stall got=%b exp=01", {issue, stall});
        end
        step();
        wb_valid = 1; wb_reg = 7;
        #2;
        n_vec++;
        if ({issue, stall} !== 2'b10) begin
            n_err++; $display("FAIL sat_wb_release got=%b exp=10", {issue, stall});
        end
        step();
        dec_valid = 0; writes_d = 0; wb_valid = 0;
        #2;
        n_vec++;
        if (dut.cnt[7] !== 2'd3) begin
            n_err++; $display("FAIL sat_cnt7_hold got=%0d exp=3", dut.cnt[7]);
        end
        wb_valid = 1;
        step(); step(); step();
        idle_inputs();
        #2;
        n_vec++;
        if (dut.cnt[7] !== 2'd0) begin
            n_err++; $display("FAIL sat_cnt7_drain got=%0d exp=0", dut.cnt[7]);
        end
        step();
    endtask

    task automatic test_simul_inc_dec();
        dec_valid = 1; writes_d = 1; reg_D = 9;
        step();
        #2;
        n_vec++;
        if (dut.cnt[9] !== 2'd1) begin
            n_err++; $display("FAIL simul_cnt9_pre got=%0d exp=1", dut.cnt[9]);
        end
        wb_valid = 1; wb_reg = 9;
        #0;
        n_vec++;
        if (issue !== 1'b1) begin
            n_err++; $display("FAIL simul_issue got=%b exp=1", issue);
        end
        step();
        dec_valid = 0; writes_d = 0; wb_valid = 0;
        #2;
        n_vec++;
        if (dut.cnt[9] !== 2'd1) begin
            n_err++; $display("FAIL simul_cnt9_post got=%0d exp=1", dut.cnt[9]);
        end
        wb_valid = 1;
        step(); step();
        idle_inputs();
        #2;
        n_vec++;
        if (dut.cnt[9] !== 2'd0) begin
            n_err++; $display("FAIL simul_wb_at_zero got=%0d exp=0", dut.cnt[9]);
        end
        step();
    endtask

    task automatic test_md();
        dec_valid = 1; is_md = 1; writes_d = 1; reg_D = 10;
        #2;
        n_vec++;
        if ({issue, md_start, md_busy} !== 3'b110) begin
            n_err++; $display("FAIL md_first_start got=%b exp=110", {issue, md_start, md_busy});
        end
        step();
        reg_D = 11;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_vec++;
            if ({stall, md_start, md_busy} !== 3'b101) begin
                n_err++; $display("FAIL md_busy_stall cyc=%0d got=%b exp=101", i, {stall, md_start, md_busy});
            end
            step();
        end
        md_done = 1;
        #2;
        n_vec++;
        if ({issue, md_start, stall} !== 3'b110) begin
            n_err++; $display("FAIL md_b2b_issue got=%b exp=110", {issue, md_start, stall});
        end
        step();
        dec_valid = 0; is_md = 0; writes_d = 0; md_done = 0;
        #2;
        n_vec++;
        if (md_busy !== 1'b1) begin
            n_err++; $display("FAIL md_b2b_busy got=%b exp=1", md_busy);
        end
        step();
        md_done = 1;
        step();
        #2;
        n_vec++;
        if (md_busy !== 1'b0) begin
            n_err++; $display("FAIL md_done_idle got=%b exp=0", md_busy);
        end
        step();
        #2;
        n_vec++;
        if (md_busy !== 1'b0) begin
            n_err++; $display("FAIL md_done_in_idle got=%b exp=0", md_busy);
        end
        idle_inputs();
        wb_valid = 1; wb_reg = 10;
        step();
        wb_reg = 11;
        step();
        idle_inputs();
    endtask

    task automatic test_flush();
        logic bad;
        dec_valid = 1; writes_d = 1; reg_D = 4;
        step(); step();
        writes_d = 0; is_md = 1;
        step();
        is_md = 0;
        #2;
        n_vec++;
        if (dut.cnt[4] !== 2'd2 || md_busy !== 1'b1) begin
            n_err++; $display("FAIL flush_setup cnt4=%0d busy=%b exp=2,1", dut.cnt[4], md_busy);
        end
        flush = 1; writes_d = 1; reg_D = 4; wb_valid = 1; wb_reg = 4;
        #0;
        n_vec++;
        if ({issue, stall, md_start} !== 3'b000) begin
            n_err++; $display("FAIL flush_outputs got=%b exp=000", {issue, stall, md_start});
        end
        step();
        idle_inputs();
        #2;
        bad = 0;
        for (int r = 0; r < 32; r++) if (dut.cnt[r] !== 2'd0) bad = 1;
        n_vec++;
        if (bad || md_busy !== 1'b0) begin
            n_err++; $display("FAIL flush_clear cnt_nonzero=%b busy=%b exp=0,0", bad, md_busy);
        end
        step();
    endtask

    task automatic test_async_reset();
        dec_valid = 1; writes_d = 1; reg_D = 12; is_md = 1;
        step();
        idle_inputs();
        #2;
        reset_n = 0;
        #1;
        n_vec++;
        if (dut.cnt[12] !== 2'd0 || md_busy !== 1'b0) begin
            n_err++; $display("FAIL async_reset cnt12=%0d busy=%b exp=0,0", dut.cnt[12], md_busy);
        end
        step();
        reset_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_r0_saturation();
        test_simul_inc_dec();
        test_md();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
